tone_scheduler: RTL and testbench
=================================

# tone_scheduler

Shares the synthesizer's single tone divider between several requesters (phoneme engine, key beeper, test generator, etc.). Each requester asks for a tone with a divisor and a duration. The block picks requesters round-robin, loads the chosen divisor into its internal divider, and plays the tone for the requested number of ticks. It then inserts a short silence and returns to idle. It sits between the request sources and the audio output stage.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DIV_W, 32, divisor width
- DUR_W, 16, duration width in ticks
- TICK_DIV, 50000, clk_in cycles per duration tick (1 ms at 50 MHz)
- GAP_CYC, 16, silence cycles after each tone (>=1)

Ports:
- clk_in, in, 1, single system clock
- rst_n, in, 1, asynchronous active-low reset
- req, in, NREQ, per-requester request level; held until grant
- req_div, in, NREQ*DIV_W, packed divisors; slot i at [i*DIV_W +: DIV_W]
- req_dur, in, NREQ*DUR_W, packed durations; slot i at [i*DUR_W +: DUR_W]
- grant, out, NREQ, one-hot, one-cycle pulse acknowledging the request
- active_id, out, clog2(NREQ), index of the current or last granted requester
- busy, out, 1, high in every state except IDLE
- done, out, 1, one-cycle pulse when the granted tone finishes normally
- abort, out, 1, one-cycle pulse when a tone is preempted (constant 0 unless the preempt feature is compiled in)
- tone_out, out, 1, square-wave output; 0 whenever no tone is playing

## Operation
States:
- IDLE: no tone playing.
- PLAY: tone is sounding.
- GAP: enforced silence between tones.

Transitions:
- IDLE -> PLAY: at any edge where req is nonzero. The winner is the first set bit searching from (last+1) mod NREQ upward, with wraparound. `last` resets to NREQ-1, so requester 0 wins first. On this edge the block:
  - latches req_div[winner] and req_dur[winner];
  - pulses grant[winner];
  - sets active_id to the winner;
  - clears the divider counter, the tick prescaler and the tick count.
- PLAY -> GAP: when the tick count equals the latched duration. done pulses and tone_out is forced to 0.
- GAP -> IDLE: after GAP_CYC cycles.

Divider behaviour in PLAY:
- The counter increments while it is less than the divisor.
- Otherwise it clears and tone_out toggles.
- Half-period is therefore div+1 cycles. div=0 toggles every cycle. Arithmetic is unsigned and DIV_W-wide.

Tick prescaler:
- Counts 0..TICK_DIV-1.
- At wrap it increments the DUR_W-bit tick count. The tick count saturates and never wraps.

Boundary cases:
- dur=0: PLAY lasts exactly one cycle, tone_out stays 0, and done pulses.
- A requester still holding req after its grant is re-queued and competes round-robin, so it gets no priority.
- req changes during PLAY or GAP are ignored, except as allowed by the preempt feature.
- Reset mid-tone: all state returns to reset values immediately. No done or abort is issued.

## Timing
- Reset values: state IDLE, grant 0, active_id 0, busy 0, done 0, abort 0, tone_out 0, all counters 0.
- All outputs are registered; no combinational path from req to grant.
- Grant latency: req sampled high at edge k -> grant high during cycle k..k+1, and busy rises at the same edge.
- First rising edge of tone_out comes div+1 cycles after the grant edge.
- done comes dur*TICK_DIV cycles after the grant edge.
- busy falls GAP_CYC cycles after done.
- Minimum spacing between grants is 1 + GAP_CYC cycles, plus the play time.

## Configuration
- Macro: TONE_SCHEDULER_PREEMPT_EN.
- Defined:
  - req[0] sampled high while in PLAY with active_id != 0 aborts the current tone.
  - abort pulses, tone_out is forced to 0, and the block enters GAP. No done is issued.
  - `last` is set to NREQ-1 so requester 0 wins the next arbitration.
  - req[0] during GAP does not shorten the gap.
- Undefined: abort is tied to 0 and requests are only considered in IDLE.

## Structure
- Shared package: state encoding enum (IDLE/PLAY/GAP), tone_scheduler default parameter constants, and a round-robin pick function taking req and last.
- One sub-module: tone_divider (clk_in, rst_n, clear, en, div, tone). It holds the counter/toggle divider and clears synchronously on clear.
- The scheduler owns the FSM, prescaler and arbitration.

## Test plan
All scenarios use TICK_DIV=4, GAP_CYC=2.
- Reset mid-tone: assert rst_n low for 1 cycle during PLAY -> all outputs are 0 immediately and the next req restarts from requester 0.
- Single request: req=0001, div=2, dur=3 -> grant=0001 one cycle, tone_out rises 3 cycles after grant with 3-cycle half-period, done 12 cycles after grant, busy low 2 cycles later.
- Round-robin: req=1111 held with each dur=1 -> grants arrive in order 0001, 0010, 0100, 1000, 0001, and active_id follows 0,1,2,3,0.
- Zero duration and zero divisor:
  - dur=0: done arrives one cycle after grant, with no tone_out activity.
  - div=0, dur=2: tone_out toggles every cycle for 8 cycles.
- Preempt (macro defined): requester 2 playing dur=100, then req[0] raised -> abort pulses, tone_out is 0, and after 2 gap cycles grant=0001. With the macro undefined, requester 2 completes and done pulses before grant=0001.

Source files
------------

// File: rtl/tone_scheduler_pkg.sv
// Shared types, default parameters and the round-robin picker for tone_scheduler.
package tone_scheduler_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} state_e;

   localparam int unsigned TS_NREQ     = 4;
   localparam int unsigned TS_DIV_W    = 32;
   localparam int unsigned TS_DUR_W    = 16;
   localparam int unsigned TS_TICK_DIV = 50000;
   localparam int unsigned TS_GAP_CYC  = 16;
   localparam int unsigned RR_MAX      = 8;

   // First set bit of req searching upward from last+1, wrapping at n (n <= RR_MAX).
   function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] req,
                                          input logic [2:0]        last,
                                          input int unsigned       n);
      logic [2:0]  win;
      logic        found;
      int unsigned idx;
      win   = '0;
      found = 1'b0;
      for (int unsigned i = 1; i <= RR_MAX; i++) begin
         idx = 32'(last) + i;
         if (idx >= n) idx = idx - n;
         if (i <= n && !found && req[idx[2:0]]) begin
            win   = idx[2:0];
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/tone_scheduler_divider.sv
// Counter/toggle tone divider: half-period of div+1 cycles while enabled.
module tone_divider #(
   parameter int unsigned DIV_W = 32
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tone
);

   logic [DIV_W-1:0] cnt_q;
   logic             tone_q;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tone_q <= 1'b0;
      end else if (clear) begin
         cnt_q  <= '0;
         tone_q <= 1'b0;
      end else if (en) begin
         if (cnt_q < div) begin
            cnt_q <= cnt_q + 1'b1;
         end else begin
            cnt_q  <= '0;
            tone_q <= ~tone_q;
         end
      end
   end

   assign tone = tone_q;

endmodule

// File: rtl/tone_scheduler.sv
// Round-robin scheduler sharing one tone divider among NREQ requesters.
// Optional preemption by requester 0 is compiled in with TONE_SCHEDULER_PREEMPT_EN.
module tone_scheduler
   import tone_scheduler_pkg::*;
#(
   parameter int unsigned NREQ     = TS_NREQ,
   parameter int unsigned DIV_W    = TS_DIV_W,
   parameter int unsigned DUR_W    = TS_DUR_W,
   parameter int unsigned TICK_DIV = TS_TICK_DIV,
   parameter int unsigned GAP_CYC  = TS_GAP_CYC,
   localparam int unsigned ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk_in,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*DIV_W-1:0] req_div,
   input  logic [NREQ*DUR_W-1:0] req_dur,
   output logic [NREQ-1:0]       grant,
   output logic [ID_W-1:0]       active_id,
   output logic                  busy,
   output logic                  done,
   output logic                  abort,
   output logic                  tone_out
);

   localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DUR_W-1:0]  dur_q, dur_d;
   logic [PRE_W-1:0]  presc_q, presc_d;
   logic [DUR_W-1:0]  tick_q, tick_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [2:0]        last_q, last_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]   active_q, active_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              div_clr;
   logic [2:0]        winner;
   logic              presc_wrap, finish;
   logic [DUR_W-1:0]  tick_nxt;

   assign winner     = rr_pick(RR_MAX'(req), last_q, NREQ);
   assign presc_wrap = (presc_q == PRE_W'(TICK_DIV - 1));
   assign tick_nxt   = (presc_wrap && tick_q != '1) ? tick_q + 1'b1 : tick_q;
   // Looking at the post-increment count lets done land exactly dur*TICK_DIV after grant.
   assign finish     = (tick_q == dur_q) || (tick_nxt == dur_q);

`ifdef TONE_SCHEDULER_PREEMPT_EN
   logic abort_q, abort_d;
`endif

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      dur_d    = dur_q;
      presc_d  = presc_q;
      tick_d   = tick_q;
      gap_d    = gap_q;
      last_d   = last_q;
      active_d = active_q;
      grant_d  = '0;
      done_d   = 1'b0;
      div_clr  = 1'b0;
`ifdef TONE_SCHEDULER_PREEMPT_EN
      abort_d  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               state_d  = ST_PLAY;
               grant_d  = NREQ'(1) << winner;
               active_d = winner[ID_W-1:0];
               last_d   = winner;
               div_d    = req_div[32'(winner)*DIV_W +: DIV_W];
               dur_d    = req_dur[32'(winner)*DUR_W +: DUR_W];
               presc_d  = '0;
               tick_d   = '0;
               div_clr  = 1'b1;
            end
         end
         ST_PLAY: begin
            if (finish) begin
               state_d = ST_GAP;
               done_d  = 1'b1;
               gap_d   = '0;
               div_clr = 1'b1;
            end
`ifdef TONE_SCHEDULER_PREEMPT_EN
            else if (req[0] && active_q != '0) begin
               state_d = ST_GAP;
               abort_d = 1'b1;
               gap_d   = '0;
               div_clr = 1'b1;
               last_d  = 3'(NREQ - 1);
            end
`endif
            else begin
               presc_d = presc_wrap ? '0 : presc_q + 1'b1;
               tick_d  = tick_nxt;
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = ST_IDLE;
            else                              gap_d   = gap_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         div_q    <= '0;
         dur_q    <= '0;
         presc_q  <= '0;
         tick_q   <= '0;
         gap_q    <= '0;
         last_q   <= 3'(NREQ - 1);
         active_q <= '0;
         grant_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef TONE_SCHEDULER_PREEMPT_EN
         abort_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         dur_q    <= dur_d;
         presc_q  <= presc_d;
         tick_q   <= tick_d;
         gap_q    <= gap_d;
         last_q   <= last_d;
         active_q <= active_d;
         grant_q  <= grant_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef TONE_SCHEDULER_PREEMPT_EN
         abort_q  <= abort_d;
`endif
      end
   end

   tone_divider #(.DIV_W(DIV_W)) u_div (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .clear  (div_clr),
      .en     (state_q == ST_PLAY),
      .div    (div_q),
      .tone   (tone_out)
   );

   assign grant     = grant_q;
   assign active_id = active_q;
   assign busy      = busy_q;
   assign done      = done_q;
`ifdef TONE_SCHEDULER_PREEMPT_EN
   assign abort     = abort_q;
`else
   assign abort     = 1'b0;
`endif

endmodule

// File: tb/tb_tone_scheduler.sv
// Directed self-checking bench for tone_scheduler (TICK_DIV=4, GAP_CYC=2).
module tb_tone_scheduler;

   localparam int NREQ  = 4;
   localparam int DIV_W = 8;
   localparam int DUR_W = 8;

   logic                  clk_in = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req;
   logic [NREQ*DIV_W-1:0] req_div;
   logic [NREQ*DUR_W-1:0] req_dur;
   logic [NREQ-1:0]       grant;
   logic [1:0]            active_id;
   logic                  busy, done, abort, tone_out;

   int n_tests = 0;
   int n_fail  = 0;

   tone_scheduler #(
      .NREQ(NREQ), .DIV_W(DIV_W), .DUR_W(DUR_W), .TICK_DIV(4), .GAP_CYC(2)
   ) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .req       (req),
      .req_div   (req_div),
      .req_dur   (req_dur),
      .grant     (grant),
      .active_id (active_id),
      .busy      (busy),
      .done      (done),
      .abort     (abort),
      .tone_out  (tone_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_slot(input int i, input int d, input int t);
      req_div[i*DIV_W +: DIV_W] = DIV_W'(d);
      req_dur[i*DUR_W +: DUR_W] = DUR_W'(t);
   endtask

   task automatic wait_grant(input int bound);
      int n = 0;
      while (grant == '0 && n < bound) begin
         step();
         n++;
      end
      chk("grant_wait", 32'(grant != '0), 32'd1);
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (busy && n < bound) begin
         step();
         n++;
      end
      chk("idle_wait", 32'(busy), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; req = '0; req_div = '0; req_dur = '0;
      step(); step();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_abort", 32'(abort), 32'd0);
      chk("rst_tone",  32'(tone_out), 32'd0);
      chk("rst_id",    32'(active_id), 32'd0);
      rst_n = 1'b1;
      step();

      // Round-robin over all four requesters held high.
      for (int i = 0; i < NREQ; i++) set_slot(i, 1, 1);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_grant(30);
         chk("rr_grant", 32'(grant), 32'(1) << (k % 4));
         chk("rr_id", 32'(active_id), 32'(k % 4));
         if (k < 4) step();
      end

      // Reset in the middle of requester 0's tone.
      step(); step();
      chk("mid_tone", 32'(tone_out), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mrst_tone", 32'(tone_out), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      step(); step();
      chk("mrst_grant", 32'(grant), 32'd0);
      rst_n = 1'b1;
      wait_grant(5);
      chk("mrst_restart", 32'(grant), 32'b0001);
      req = '0;
      wait_idle(30);

      // Single request: div=2, dur=3.
      set_slot(0, 2, 3);
      req = 4'b0001;
      step();
      chk("s_grant", 32'(grant), 32'b0001);
      chk("s_busy", 32'(busy), 32'd1);
      req = '0;
      for (int n = 1; n <= 14; n++) begin
         step();
         if (n == 1)  chk("s_grant_pulse", 32'(grant), 32'd0);
         if (n <= 11) chk("s_tone", 32'(tone_out), 32'((n / 3) % 2));
         if (n == 11) chk("s_done_early", 32'(done), 32'd0);
         if (n == 12) begin
            chk("s_done", 32'(done), 32'd1);
            chk("s_tone_off", 32'(tone_out), 32'd0);
         end
         if (n == 13) begin
            chk("s_done_pulse", 32'(done), 32'd0);
            chk("s_busy_gap", 32'(busy), 32'd1);
         end
         if (n == 14) chk("s_busy_fall", 32'(busy), 32'd0);
      end

      // Zero duration.
      set_slot(2, 5, 0);
      req = 4'b0100;
      step();
      chk("z_grant", 32'(grant), 32'b0100);
      req = '0;
      step();
      chk("z_done", 32'(done), 32'd1);
      chk("z_tone", 32'(tone_out), 32'd0);
      step();
      chk("z_done_pulse", 32'(done), 32'd0);
      chk("z_busy_gap", 32'(busy), 32'd1);
      step();
      chk("z_busy_fall", 32'(busy), 32'd0);

      // Zero divisor, dur=2: toggle every cycle.
      set_slot(3, 0, 2);
      req = 4'b1000;
      step();
      chk("d0_grant", 32'(grant), 32'b1000);
      chk("d0_id", 32'(active_id), 32'd3);
      req = '0;
      for (int n = 1; n <= 8; n++) begin
         step();
         if (n < 8) chk("d0_tone", 32'(tone_out), 32'(n % 2));
         else begin
            chk("d0_done", 32'(done), 32'd1);
            chk("d0_tone_off", 32'(tone_out), 32'd0);
         end
      end
      wait_idle(10);

      // Requester 2 playing a long tone, then requester 0 asks.
      set_slot(2, 3, 100);
      set_slot(0, 1, 1);
      req = 4'b0100;
      step();
      chk("p_grant", 32'(grant), 32'b0100);
      req = '0;
      repeat (13) step();
      chk("p_tone", 32'(tone_out), 32'd1);
      req = 4'b0001;
`ifdef TONE_SCHEDULER_PREEMPT_EN
      step();
      chk("p_abort", 32'(abort), 32'd1);
      chk("p_tone_off", 32'(tone_out), 32'd0);
      chk("p_no_done", 32'(done), 32'd0);
      chk("p_busy", 32'(busy), 32'd1);
      step();
      chk("p_abort_pulse", 32'(abort), 32'd0);
      step();
      chk("p_gap_end", 32'(busy), 32'd0);
      step();
      chk("p_grant0", 32'(grant), 32'b0001);
`else
      begin
         int n = 0;
         int gseen = 0;
         while (!done && n < 500) begin
            step();
            n++;
            if (grant != '0) gseen++;
            if (abort) gseen++;
         end
         chk("np_done", 32'(done), 32'd1);
         chk("np_no_early_grant", 32'(gseen), 32'd0);
         chk("np_id", 32'(active_id), 32'd2);
         wait_grant(10);
         chk("np_grant0", 32'(grant), 32'b0001);
      end
`endif
      req = '0;
      wait_idle(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
